// File: rtl/ava_vram_arbiter.sv
// ---------------------------------------------------------------------------
// ava_vram_arbiter
//
// Purpose:
//   Lets two requesters share one single-port synchronous framebuffer VRAM:
//   the pixel-fetch path (reads only) and the CPU bus port (reads and writes).
//   At most one access is granted per cycle. Grant priority comes from three
//   sources: a CPU starvation bound, pixel-FIFO urgency, and alternation.
//   Read data from the VRAM comes back one cycle after the read is granted.
//   It is steered to whichever requester issued that read.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset (0 = in reset)
//   pix_req_*      pixel read request (valid/addr), pix_req_ready = granted
//   pix_rsp_*      pixel read response (valid/data), 1 cycle after grant
//   fifo_level     pixel FIFO occupancy, drives urgency
//   cpu_req_*      CPU request (valid/we/addr/wdata), cpu_req_ready = granted
//   cpu_rsp_*      CPU read response (valid/rdata), reads only
//   mem_*          VRAM control/address/data, mem_rdata valid 1 cycle later
// ---------------------------------------------------------------------------
module ava_vram_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 8,
    parameter int LEVEL_W      = 5,
    parameter int URGENT_LEVEL = 4,
    parameter int CPU_MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              pix_req_valid,
    input  logic [ADDR_W-1:0] pix_req_addr,
    output logic              pix_req_ready,
    output logic              pix_rsp_valid,
    output logic [DATA_W-1:0] pix_rsp_data,
    input  logic [LEVEL_W-1:0] fifo_level,

    input  logic              cpu_req_valid,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_req_ready,
    output logic              cpu_rsp_valid,
    output logic [DATA_W-1:0] cpu_rsp_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // The counter must be able to hold CPU_MAX_WAIT itself. The guard keeps
    // the width legal for a degenerate bound of zero.
    localparam int WAIT_W = (CPU_MAX_WAIT > 0) ? $clog2(CPU_MAX_WAIT + 1) : 1;

    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(CPU_MAX_WAIT);
    localparam logic [LEVEL_W-1:0] URGENT_LVL = LEVEL_W'(URGENT_LEVEL);

    typedef enum logic {
        GRANT_PIX = 1'b0,
        GRANT_CPU = 1'b1
    } requester_t;

    requester_t        last_grant;
    logic [WAIT_W-1:0] cpu_wait_cnt;
    logic              pix_rsp_valid_q;
    logic              cpu_rsp_valid_q;

    logic              grant_pix;
    logic              grant_cpu;
    logic              pix_urgent;
    logic              cpu_starved;

    assign pix_urgent  = (fifo_level < URGENT_LVL);
    assign cpu_starved = (cpu_wait_cnt == WAIT_MAX);

    // Grant selection. Every grant is qualified by reset, so all
    // combinational outputs fall to zero while reset is held low, even if
    // requesters keep their valids high.
    always_comb begin
        grant_pix = 1'b0;
        grant_cpu = 1'b0;
        if (reset) begin
            if (pix_req_valid && cpu_req_valid) begin
                // Contested cycle: the starvation bound outranks urgency.
                // Urgency outranks plain alternation.
                if (cpu_starved) begin
                    grant_cpu = 1'b1;
                end else if (pix_urgent) begin
                    grant_pix = 1'b1;
                end else if (last_grant == GRANT_CPU) begin
                    grant_pix = 1'b1;
                end else begin
                    grant_cpu = 1'b1;
                end
            end else if (pix_req_valid) begin
                grant_pix = 1'b1;
            end else if (cpu_req_valid) begin
                grant_cpu = 1'b1;
            end
        end
    end

    assign pix_req_ready = grant_pix;
    assign cpu_req_ready = grant_cpu;

    // The VRAM port is driven straight from the granted request, so a grant
    // and its memory access happen in the same cycle. The port is driven
    // with zeros when nothing is granted.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_cpu) begin
            mem_en    = 1'b1;
            mem_we    = cpu_req_we;
            mem_addr  = cpu_req_addr;
            mem_wdata = cpu_req_wdata;
        end else if (grant_pix) begin
            mem_en    = 1'b1;
            mem_addr  = pix_req_addr;
        end
    end

    // Arbitration history and the response pipeline.
    // Only one grant exists per cycle, so the two response valids can
    // never be high together. An asynchronous reset clears a pending
    // response, which discards a read that was granted in the cycle
    // before reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant      <= GRANT_CPU;
            cpu_wait_cnt    <= '0;
            pix_rsp_valid_q <= 1'b0;
            cpu_rsp_valid_q <= 1'b0;
        end else begin
            pix_rsp_valid_q <= grant_pix;
            cpu_rsp_valid_q <= grant_cpu && !cpu_req_we;

            if (grant_pix) begin
                last_grant <= GRANT_PIX;
            end else if (grant_cpu) begin
                last_grant <= GRANT_CPU;
            end

            // Count only the cycles where the CPU is waiting and loses to
            // the pixel path. The count saturates at the forcing bound.
            if (grant_cpu || !cpu_req_valid) begin
                cpu_wait_cnt <= '0;
            end else if (grant_pix && !cpu_starved) begin
                cpu_wait_cnt <= cpu_wait_cnt + WAIT_W'(1);
            end
        end
    end

    assign pix_rsp_valid = pix_rsp_valid_q;
    assign cpu_rsp_valid = cpu_rsp_valid_q;

    // Read data passes straight through from the VRAM. It is only
    // meaningful while the matching response valid is high.
    assign pix_rsp_data  = reset ? mem_rdata : '0;
    assign cpu_rsp_rdata = reset ? mem_rdata : '0;

endmodule

// File: tb/tb_ava_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ava_vram_arbiter
//
// Purpose:
//   Self-checking bench for ava_vram_arbiter. A behavioural VRAM with one
//   cycle of read latency sits on the memory port. A separate reference
//   model predicts grants, responses and read data from the arbitration
//   rules: plain integers for the wait count and history, plus a shadow
//   memory array.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_ava_vram_arbiter;

    localparam int ADDR_W       = 17;
    localparam int DATA_W       = 8;
    localparam int LEVEL_W      = 5;
    localparam int URGENT_LEVEL = 4;
    localparam int CPU_MAX_WAIT = 3;
    localparam int MEM_WORDS    = 1 << ADDR_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               pix_req_valid;
    logic [ADDR_W-1:0]  pix_req_addr;
    logic               pix_req_ready;
    logic               pix_rsp_valid;
    logic [DATA_W-1:0]  pix_rsp_data;
    logic [LEVEL_W-1:0] fifo_level;
    logic               cpu_req_valid;
    logic               cpu_req_we;
    logic [ADDR_W-1:0]  cpu_req_addr;
    logic [DATA_W-1:0]  cpu_req_wdata;
    logic               cpu_req_ready;
    logic               cpu_rsp_valid;
    logic [DATA_W-1:0]  cpu_rsp_rdata;
    logic               mem_en;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ava_vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEVEL_W(LEVEL_W),
        .URGENT_LEVEL(URGENT_LEVEL), .CPU_MAX_WAIT(CPU_MAX_WAIT)
    ) dut (
        .clk(clk), .reset(reset),
        .pix_req_valid(pix_req_valid), .pix_req_addr(pix_req_addr),
        .pix_req_ready(pix_req_ready), .pix_rsp_valid(pix_rsp_valid),
        .pix_rsp_data(pix_rsp_data), .fifo_level(fifo_level),
        .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_req_ready(cpu_req_ready), .cpu_rsp_valid(cpu_rsp_valid),
        .cpu_rsp_rdata(cpu_rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Gives the power-up contents of every VRAM word as a fixed function
    // of its address.
    function automatic logic [DATA_W-1:0] init_word(logic [ADDR_W-1:0] a);
        return a[7:0] ^ {a[16:13], a[11:8]} ^ 8'h3c;
    endfunction

    // Behavioural single-port VRAM. A word that was never written reads
    // back its power-up value.
    bit                env_written [MEM_WORDS];
    logic [DATA_W-1:0] env_mem     [MEM_WORDS];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                env_mem[mem_addr]     <= mem_wdata;
                env_written[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= env_written[mem_addr] ? env_mem[mem_addr] : init_word(mem_addr);
            end
        end
    end

    // Reference model state: expected VRAM contents, arbitration history,
    // and the response expected in the next cycle.
    logic [DATA_W-1:0] ref_mem [MEM_WORDS];
    int                m_wait;
    bit                m_last_cpu;
    bit                e_pix_rv;
    bit                e_cpu_rv;
    logic [DATA_W-1:0] e_data;

    function automatic void model_reset();
        m_wait     = 0;
        m_last_cpu = 1'b1;
        e_pix_rv   = 1'b0;
        e_cpu_rv   = 1'b0;
        e_data     = '0;
    endfunction

    // Returns 0 = no grant, 1 = pixel, 2 = CPU.
    function automatic int model_grant();
        if (pix_req_valid && cpu_req_valid) begin
            if (m_wait == CPU_MAX_WAIT) return 2;
            if (int'(fifo_level) < URGENT_LEVEL) return 1;
            return m_last_cpu ? 1 : 2;
        end
        if (pix_req_valid) return 1;
        if (cpu_req_valid) return 2;
        return 0;
    endfunction

    function automatic void model_commit(int g);
        e_pix_rv = (g == 1);
        e_cpu_rv = (g == 2) && !cpu_req_we;
        if (g == 1) begin
            e_data = ref_mem[pix_req_addr];
        end else if (g == 2) begin
            if (cpu_req_we) ref_mem[cpu_req_addr] = cpu_req_wdata;
            else e_data = ref_mem[cpu_req_addr];
        end
        if (g == 1) m_last_cpu = 1'b0;
        else if (g == 2) m_last_cpu = 1'b1;
        if (g == 2 || !cpu_req_valid) m_wait = 0;
        else if (g == 1 && m_wait < CPU_MAX_WAIT) m_wait++;
    endfunction

    task automatic drive(bit pv, logic [ADDR_W-1:0] pa, bit cv, bit cw,
                         logic [ADDR_W-1:0] ca, logic [DATA_W-1:0] cd, int lvl);
        pix_req_valid = pv;
        pix_req_addr  = pa;
        cpu_req_valid = cv;
        cpu_req_we    = cw;
        cpu_req_addr  = ca;
        cpu_req_wdata = cd;
        fifo_level    = LEVEL_W'(lvl);
    endtask

    // Reset held low with both requesters active must silence every
    // output. The first contested cycle after release goes to pixel.
    task automatic test_reset();
        int g;
        reset = 1'b0;
        drive(1, 17'h00100, 1, 0, 17'h00200, 8'h00, 10);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (pix_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset pix_ready: got %b expected 0", pix_req_ready); end
        checks++; if (cpu_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset cpu_ready: got %b expected 0", cpu_req_ready); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL reset mem_en: got %b expected 0", mem_en); end
        checks++; if (mem_addr !== '0) begin errors++; $display("[TB] FAIL reset mem_addr: got %h expected 0", mem_addr); end
        checks++; if (pix_rsp_valid !== 1'b0 || cpu_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset rsp_valid: got %b%b expected 00", pix_rsp_valid, cpu_rsp_valid); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        g = model_grant();
        checks++; if (pix_req_ready !== 1'b1 || cpu_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL first grant: got pix=%b cpu=%b expected pix=1 cpu=0", pix_req_ready, cpu_req_ready); end
        checks++; if (mem_addr !== 17'h00100) begin errors++; $display("[TB] FAIL first mem_addr: got %h expected 00100", mem_addr); end
        model_commit(g);
        @(posedge clk); #1;
    endtask

    // Continuous contention without urgency must alternate. Each pixel
    // read must return the VRAM contents one cycle later.
    task automatic test_alternation();
        int g;
        bit new_p, new_c;
        drive(1, 17'(($urandom_range(0, 4095))), 1, 0, 17'($urandom_range(0, 4095)), 8'h00, 10);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            g = model_grant();
            checks++; if (pix_req_ready !== (g == 1) || cpu_req_ready !== (g == 2)) begin errors++; $display("[TB] FAIL alt grant %0d: got pix=%b cpu=%b expected grant %0d", i, pix_req_ready, cpu_req_ready, g); end
            checks++; if (pix_rsp_valid !== e_pix_rv || cpu_rsp_valid !== e_cpu_rv) begin errors++; $display("[TB] FAIL alt rsp_valid %0d: got %b%b expected %b%b", i, pix_rsp_valid, cpu_rsp_valid, e_pix_rv, e_cpu_rv); end
            if (e_pix_rv) begin
                checks++; if (pix_rsp_data !== e_data) begin errors++; $display("[TB] FAIL alt pix_data %0d: got %h expected %h", i, pix_rsp_data, e_data); end
            end
            if (e_cpu_rv) begin
                checks++; if (cpu_rsp_rdata !== e_data) begin errors++; $display("[TB] FAIL alt cpu_data %0d: got %h expected %h", i, cpu_rsp_rdata, e_data); end
            end
            new_p = (g == 1);
            new_c = (g == 2);
            model_commit(g);
            @(posedge clk); #1;
            if (new_p) pix_req_addr = 17'($urandom_range(0, 4095));
            if (new_c) cpu_req_addr = 17'($urandom_range(0, 4095));
        end
    endtask

    // Under constant urgency the CPU is forced through on every fourth
    // contested cycle.
    task automatic test_starvation();
        int    g;
        byte   got;
        string pat;
        pat = "PPPCPPPC";
        drive(0, 17'h00040, 1, 0, 17'h00080, 8'h00, 2);
        @(negedge clk);
        g = model_grant();
        model_commit(g);
        @(posedge clk); #1;
        pix_req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            g = model_grant();
            got = pix_req_ready ? "P" : (cpu_req_ready ? "C" : "-");
            checks++; if (got !== pat[i]) begin errors++; $display("[TB] FAIL starve grant %0d: got %c expected %c", i, got, pat[i]); end
            checks++; if (pix_rsp_valid !== e_pix_rv || cpu_rsp_valid !== e_cpu_rv) begin errors++; $display("[TB] FAIL starve rsp_valid %0d: got %b%b expected %b%b", i, pix_rsp_valid, cpu_rsp_valid, e_pix_rv, e_cpu_rv); end
            model_commit(g);
            @(posedge clk); #1;
            pix_req_addr = pix_req_addr + 17'd1;
        end
    endtask

    // A CPU write followed directly by a read of the same word returns the
    // new data. The write itself produces no response.
    task automatic test_write_read();
        int g;
        drive(0, 17'h0, 1, 1, 17'h12C00, 8'hA5, 10);
        @(negedge clk);
        g = model_grant();
        checks++; if (cpu_req_ready !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("[TB] FAIL wr grant: got ready=%b we=%b expected 1 1", cpu_req_ready, mem_we); end
        checks++; if (mem_addr !== 17'h12C00 || mem_wdata !== 8'hA5) begin errors++; $display("[TB] FAIL wr bus: got %h/%h expected 12c00/a5", mem_addr, mem_wdata); end
        model_commit(g);
        @(posedge clk); #1;
        cpu_req_we = 1'b0;
        @(negedge clk);
        g = model_grant();
        checks++; if (cpu_req_ready !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rd grant: got ready=%b we=%b expected 1 0", cpu_req_ready, mem_we); end
        checks++; if (cpu_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL wr rsp: got %b expected 0", cpu_rsp_valid); end
        model_commit(g);
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        @(negedge clk);
        g = model_grant();
        checks++; if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== 8'hA5) begin errors++; $display("[TB] FAIL rd rsp: got %b/%h expected 1/a5", cpu_rsp_valid, cpu_rsp_rdata); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL idle mem_en: got %b expected 0", mem_en); end
        model_commit(g);
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (cpu_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rd rsp len: got %b expected 0", cpu_rsp_valid); end
        @(posedge clk); #1;
    endtask

    // A level equal to the threshold is not urgent. One below it is urgent.
    task automatic test_urgency_threshold();
        int g;
        drive(1, 17'h00300, 0, 0, 17'h00400, 8'h00, 4);
        @(negedge clk); g = model_grant(); model_commit(g);
        @(posedge clk); #1;
        cpu_req_valid = 1'b1;
        @(negedge clk);
        g = model_grant();
        checks++; if (cpu_req_ready !== 1'b1 || pix_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL level4 grant: got pix=%b cpu=%b expected cpu", pix_req_ready, cpu_req_ready); end
        model_commit(g);
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        @(negedge clk); g = model_grant(); model_commit(g);
        @(posedge clk); #1;
        cpu_req_valid = 1'b1;
        fifo_level    = 5'd3;
        @(negedge clk);
        g = model_grant();
        checks++; if (pix_req_ready !== 1'b1 || cpu_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL level3 grant: got pix=%b cpu=%b expected pix", pix_req_ready, cpu_req_ready); end
        model_commit(g);
        @(posedge clk); #1;
    endtask

    // Reset asserted in the cycle of a pixel grant must suppress its
    // response. After release the arbiter behaves as if freshly reset.
    task automatic test_reset_mid();
        int g;
        drive(1, 17'h00500, 0, 0, 17'h0, 8'h00, 10);
        @(negedge clk);
        checks++; if (pix_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid grant: got %b expected 1", pix_req_ready); end
        #1 reset = 1'b0;
        #1;
        checks++; if (pix_req_ready !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("[TB] FAIL mid async: got ready=%b en=%b expected 0 0", pix_req_ready, mem_en); end
        checks++; if (pix_rsp_valid !== 1'b0 || pix_rsp_data !== '0) begin errors++; $display("[TB] FAIL mid rsp clear: got %b/%h expected 0/00", pix_rsp_valid, pix_rsp_data); end
        @(posedge clk); #1;
        checks++; if (pix_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid rsp N+1: got %b expected 0", pix_rsp_valid); end
        reset = 1'b1;
        model_reset();
        drive(1, 17'h00600, 1, 0, 17'h00700, 8'h00, 10);
        @(negedge clk);
        g = model_grant();
        checks++; if (pix_req_ready !== 1'b1 || cpu_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid resume: got pix=%b cpu=%b expected pix", pix_req_ready, cpu_req_ready); end
        checks++; if (pix_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid resume rsp: got %b expected 0", pix_rsp_valid); end
        model_commit(g);
        @(posedge clk); #1;
    endtask

    // Random mixed traffic over a small window at the top of the address
    // space, so writes and reads often hit the same words. A requester
    // that was not granted holds its request stable.
    task automatic test_random();
        int g;
        bit pend_p = 1'b0;
        bit pend_c = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pend_p) begin
                pix_req_valid = ($urandom_range(0, 9) < 7);
                pix_req_addr  = 17'h1FFF0 + 17'($urandom_range(0, 15));
            end
            if (!pend_c) begin
                cpu_req_valid = ($urandom_range(0, 9) < 6);
                cpu_req_we    = 1'($urandom_range(0, 1));
                cpu_req_addr  = 17'h1FFF0 + 17'($urandom_range(0, 15));
                cpu_req_wdata = 8'($urandom);
            end
            fifo_level = 5'($urandom_range(0, 20));
            @(negedge clk);
            g = model_grant();
            checks++; if (pix_req_ready !== (g == 1) || cpu_req_ready !== (g == 2)) begin errors++; $display("[TB] FAIL rnd grant %0d: got pix=%b cpu=%b expected grant %0d", i, pix_req_ready, cpu_req_ready, g); end
            checks++; if (mem_en !== (g != 0) || mem_we !== (g == 2 && cpu_req_we)) begin errors++; $display("[TB] FAIL rnd mem ctl %0d: got en=%b we=%b", i, mem_en, mem_we); end
            checks++; if (mem_addr !== ((g == 1) ? pix_req_addr : (g == 2) ? cpu_req_addr : '0)) begin errors++; $display("[TB] FAIL rnd mem_addr %0d: got %h", i, mem_addr); end
            checks++; if (mem_wdata !== ((g == 2) ? cpu_req_wdata : '0)) begin errors++; $display("[TB] FAIL rnd mem_wdata %0d: got %h", i, mem_wdata); end
            checks++; if (pix_rsp_valid !== e_pix_rv || cpu_rsp_valid !== e_cpu_rv) begin errors++; $display("[TB] FAIL rnd rsp_valid %0d: got %b%b expected %b%b", i, pix_rsp_valid, cpu_rsp_valid, e_pix_rv, e_cpu_rv); end
            if (e_pix_rv) begin
                checks++; if (pix_rsp_data !== e_data) begin errors++; $display("[TB] FAIL rnd pix_data %0d: got %h expected %h", i, pix_rsp_data, e_data); end
            end
            if (e_cpu_rv) begin
                checks++; if (cpu_rsp_rdata !== e_data) begin errors++; $display("[TB] FAIL rnd cpu_data %0d: got %h expected %h", i, cpu_rsp_rdata, e_data); end
            end
            pend_p = pix_req_valid && (g != 1);
            pend_c = cpu_req_valid && (g != 2);
            model_commit(g);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(0, '0, 0, 0, '0, '0, 0);
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(17'(i));
        $display("[TB] starting ava_vram_arbiter bench");
        test_reset();
        test_alternation();
        test_starvation();
        test_write_read();
        test_urgency_threshold();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ava_vram_arbiter.md
Name: ava_vram_arbiter

Overview:
- Shares the single-port synchronous framebuffer VRAM between two requesters:
  - the pixel-fetch path, which reads pixels for the coordinate stream and fills the pixel FIFO;
  - the CPU bus port, which performs reads and writes.
- Grants at most one access per cycle. Priority comes from pixel-FIFO urgency, alternation, and a CPU starvation bound.
- Routes 1-cycle read data back to the requester that issued the read.

Parameters:
- ADDR_W, 17, VRAM word address width (320x240 = 76800 words).
- DATA_W, 8, VRAM word width.
- LEVEL_W, 5, width of pixel FIFO fill level.
- URGENT_LEVEL, 4, pixel FIFO level strictly below which pixel fetch is urgent.
- CPU_MAX_WAIT, 3, number of contested cycles a CPU request may lose before it is forced through.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- pix_req_valid  in  1  pixel fetch read request.
- pix_req_addr  in  ADDR_W  pixel read address.
- pix_req_ready  out  1  pixel request granted this cycle.
- pix_rsp_valid  out  1  pixel read data valid.
- pix_rsp_data  out  DATA_W  pixel read data.
- fifo_level  in  LEVEL_W  current pixel FIFO occupancy.
- cpu_req_valid  in  1  CPU access request.
- cpu_req_we  in  1  1 = write, 0 = read.
- cpu_req_addr  in  ADDR_W  CPU address.
- cpu_req_wdata  in  DATA_W  CPU write data.
- cpu_req_ready  out  1  CPU request granted this cycle.
- cpu_rsp_valid  out  1  CPU read data valid (reads only).
- cpu_rsp_rdata  out  DATA_W  CPU read data.
- mem_en  out  1  VRAM enable.
- mem_we  out  1  VRAM write enable.
- mem_addr  out  ADDR_W  VRAM address.
- mem_wdata  out  DATA_W  VRAM write data.
- mem_rdata  in  DATA_W  VRAM read data, valid the cycle after a read enable.

Behaviour:
- Reset (reset=0, asynchronous): all registered state cleared.
  - pix_rsp_valid = cpu_rsp_valid = 0, cpu_wait_cnt = 0, last_grant = CPU.
  - Any in-flight read response is discarded.
  - Combinational outputs are 0 while reset is asserted.
- Transfer occurs when valid && ready. Ready is combinational and may depend on valid.
  - Requesters must hold addr/data/we stable while valid && !ready.
- Grant decision, evaluated every cycle:
  - Neither valid: no grant, mem_en = 0.
  - Exactly one valid: grant it.
  - Both valid:
    1. cpu_wait_cnt == CPU_MAX_WAIT: grant CPU.
    2. Else fifo_level < URGENT_LEVEL: grant pixel.
    3. Else grant the requester not equal to last_grant.
- Memory drive (combinational from the granted request):
  - mem_en = 1 on any grant.
  - mem_we = cpu_req_we when CPU is granted, 0 when pixel is granted.
  - mem_addr and mem_wdata come from the granted requester; they are 0 when no grant.
- last_grant updates on every grant to the granted requester. It holds when there is no grant.
- cpu_wait_cnt:
  - Cleared on a CPU grant or when cpu_req_valid = 0.
  - Otherwise increments, saturating at CPU_MAX_WAIT, on each cycle where cpu_req_valid = 1 and the pixel requester is granted.
  - Width is clog2(CPU_MAX_WAIT+1).
- Response pipeline, latency exactly 1 cycle:
  - pix_rsp_valid is registered to 1 the cycle after a pixel grant.
  - cpu_rsp_valid is registered to 1 the cycle after a CPU read grant. CPU writes produce no response.
  - pix_rsp_data and cpu_rsp_rdata = mem_rdata (pass-through); they are meaningful only while the matching valid is high.
  - The two response valids are never high in the same cycle.
- Back-to-back grants are allowed every cycle. There is no bubble between a write and a following read, including to the same address.
- Bandwidth guarantees:
  - Under continuous contention with no urgency, grants alternate 1:1.
  - Under continuous urgency, the CPU is granted at least once every CPU_MAX_WAIT+1 cycles.
- Boundaries:
  - fifo_level == URGENT_LEVEL is not urgent.
  - Reset asserted in the cycle after a grant suppresses that grant's response.

Test Plan:
- Reset: hold reset=0 with both valids high -> all outputs 0; release -> first contested cycle with fifo_level=10 grants pixel (last_grant = CPU).
- Alternation: both valid continuously, fifo_level=10 -> grants P,C,P,C…; each pixel grant gives pix_rsp_valid one cycle later with pix_rsp_data equal to the VRAM contents at that address.
- Starvation: both valid, fifo_level=2 (urgent), CPU_MAX_WAIT=3 -> grants P,P,P,C,P,P,P,C; cpu_wait_cnt sequence 1,2,3,0.
- CPU write then read: CPU writes 0xA5 to addr 0x12C00 then reads it the next cycle, pixel idle -> mem_we 1 then 0; cpu_rsp_valid=1 with cpu_rsp_rdata=0xA5 exactly one cycle after the read grant; no response for the write.
- Urgency threshold: both valid, last_grant = pixel, fifo_level=4 -> CPU granted; fifo_level=3 -> pixel granted.
- Reset mid-operation: pixel granted at cycle N, reset=0 asynchronously during cycle N -> pix_rsp_valid stays 0 at N+1; after release the arbiter resumes from reset state.
